// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared display constants and segment table for the digit scanner
package seg7_scan_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first so the index equals the nibble.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// rtl/seg7_scan_hex7seg.sv - combinational hex nibble to active-low seven-segment lookup
module hex7seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scanner with per-frame shadowed display data
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 131072,
    parameter int BLANK    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CNT_W = min1_clog2(SCAN_DIV);
    localparam int IDX_W = min1_clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_enable_d;
    logic [DIGITS-1:0][3:0]   r_value;
    logic [DIGITS-1:0]        r_blank;
    logic [DIGITS-1:0]        r_dp;
    logic [DIGITS-1:0]        r_an;
    logic [7:0]               r_seg;
    logic                     r_frame_done;

    logic                     w_cnt_wrap;
    logic                     w_frame_wrap;
    logic                     w_latch;
    logic                     w_dark;
    logic [6:0]               w_hex;
    logic [DIGITS-1:0]        w_an_next;
    logic [7:0]               w_seg_next;

    assign w_cnt_wrap   = (r_cnt == CNT_MAX);
    assign w_frame_wrap = w_cnt_wrap && (r_idx == IDX_MAX);
    // Shadow reload at every frame boundary and on the first cycle of a fresh enable.
    assign w_latch      = enable && (!r_enable_d || w_frame_wrap);
    assign w_dark       = !enable || (r_cnt < BLANK_END) || r_blank[r_idx];

    hex7seg u_hex7seg (
        .i_nibble (r_value[r_idx]),
        .o_seg    (w_hex)
    );

    always_comb begin
        w_an_next  = '1;
        w_seg_next = SEG_OFF;
        if (!w_dark) begin
            w_an_next[r_idx] = 1'b0;
            w_seg_next       = {~r_dp[r_idx], w_hex};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_enable_d   <= 1'b0;
            r_value      <= '0;
            r_blank      <= '0;
            r_dp         <= '0;
            r_an         <= '1;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_enable_d   <= enable;
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_frame_done <= enable && w_frame_wrap;
            if (!enable) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else begin
                r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
                if (w_cnt_wrap) begin
                    r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
                end
            end
            if (w_latch) begin
                r_value <= value;
                r_blank <= blank;
                r_dp    <= dp;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan
module tb_seg7_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    logic [31:0] value8 = 32'h76543210;
    logic [7:0]  blank8 = 8'h00;
    logic [7:0]  dp8 = 8'h00;
    logic [7:0]  an8;
    logic [7:0]  seg8;
    logic        fd8;

    int checks = 0;
    int failures = 0;

    logic [3:0] an_tab [4]   = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_3210 [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .BLANK(1)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .blank      (blank),
        .dp         (dp),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    seg7_scan #(.DIGITS(8), .SCAN_DIV(8), .BLANK(3)) u_dut8 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .value      (value8),
        .blank      (blank8),
        .dp         (dp8),
        .an         (an8),
        .seg        (seg8),
        .frame_done (fd8)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        value  = 16'h3210;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (an !== 4'hF) begin failures++; $display("FAIL reset_an cyc=%0d got=%h exp=F", i, an); end
            checks++;
            if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg cyc=%0d got=%h exp=FF", i, seg); end
            checks++;
            if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd cyc=%0d got=%b exp=0", i, frame_done); end
            checks++;
            if (an8 !== 8'hFF) begin failures++; $display("FAIL reset_an8 cyc=%0d got=%h exp=FF", i, an8); end
        end
        reset = 1'b1;
    endtask

    task automatic test_scan_order();
        for (int k = 0; k < 32; k++) begin
            int c;
            int d;
            tick();
            c = k % 4;
            d = (k / 4) % 4;
            checks++;
            if (an !== ((c == 0) ? 4'hF : an_tab[d])) begin
                failures++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, an, (c == 0) ? 4'hF : an_tab[d]);
            end
            checks++;
            if (seg !== ((c == 0) ? 8'hFF : seg_3210[d])) begin
                failures++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, (c == 0) ? 8'hFF : seg_3210[d]);
            end
            checks++;
            if (frame_done !== ((k % 16) == 15)) begin
                failures++; $display("FAIL scan_fd k=%0d got=%b exp=%b", k, frame_done, (k % 16) == 15);
            end
        end
    endtask

    task automatic test_shadow();
        for (int k = 0; k < 32; k++) begin
            int c;
            int d;
            logic [7:0] exp_seg;
            if (k == 6) value = 16'hFFFF;
            tick();
            c = k % 4;
            d = (k / 4) % 4;
            exp_seg = (c == 0) ? 8'hFF : ((k < 16) ? seg_3210[d] : 8'h8E);
            checks++;
            if (an !== ((c == 0) ? 4'hF : an_tab[d])) begin
                failures++; $display("FAIL shadow_an k=%0d got=%h exp=%h", k, an, (c == 0) ? 4'hF : an_tab[d]);
            end
            checks++;
            if (seg !== exp_seg) begin
                failures++; $display("FAIL shadow_seg k=%0d got=%h exp=%h", k, seg, exp_seg);
            end
        end
    endtask

    task automatic test_blank_dp();
        value = 16'h3210;
        blank = 4'b0100;
        dp    = 4'b0001;
        repeat (16) tick();
        for (int k = 0; k < 16; k++) begin
            int c;
            int d;
            logic [3:0] exp_an;
            logic [7:0] exp_seg;
            tick();
            c = k % 4;
            d = k / 4;
            if (c == 0 || d == 2) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = an_tab[d];
                exp_seg = (d == 0) ? 8'h40 : seg_3210[d];
            end
            checks++;
            if (an !== exp_an) begin failures++; $display("FAIL blank_an k=%0d got=%h exp=%h", k, an, exp_an); end
            checks++;
            if (seg !== exp_seg) begin failures++; $display("FAIL blank_seg k=%0d got=%h exp=%h", k, seg, exp_seg); end
        end
    endtask

    task automatic test_enable_drop();
        blank = 4'b0000;
        dp    = 4'b0000;
        repeat (16) tick();
        repeat (10) tick();
        checks++;
        if (an !== 4'hB || seg !== 8'hA4) begin
            failures++; $display("FAIL drop_pre got=%h/%h exp=B/A4", an, seg);
        end
        enable = 1'b0;
        value  = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (an !== 4'hF || seg !== 8'hFF) begin
                failures++; $display("FAIL drop_dark cyc=%0d got=%h/%h exp=F/FF", i, an, seg);
            end
            checks++;
            if (frame_done !== 1'b0) begin failures++; $display("FAIL drop_fd cyc=%0d got=%b exp=0", i, frame_done); end
        end
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            int c;
            int d;
            tick();
            c = k % 4;
            d = k / 4;
            checks++;
            if (an !== ((c == 0) ? 4'hF : an_tab[d])) begin
                failures++; $display("FAIL restart_an k=%0d got=%h exp=%h", k, an, (c == 0) ? 4'hF : an_tab[d]);
            end
            checks++;
            if (seg !== ((c == 0) ? 8'hFF : 8'h92)) begin
                failures++; $display("FAIL restart_seg k=%0d got=%h exp=%h", k, seg, (c == 0) ? 8'hFF : 8'h92);
            end
            checks++;
            if (frame_done !== (k == 15)) begin
                failures++; $display("FAIL restart_fd k=%0d got=%b exp=%b", k, frame_done, k == 15);
            end
        end
    endtask

    task automatic test_params();
        int n;
        n = 0;
        while (fd8 !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (fd8 !== 1'b1) begin failures++; $display("FAIL p8_first_fd timeout after %0d cycles", n); end
        checks++;
        if (an8 !== 8'h7F || seg8 !== 8'hF8) begin
            failures++; $display("FAIL p8_last_digit got=%h/%h exp=7F/F8", an8, seg8);
        end
        n = 0;
        do begin tick(); n++; end while (fd8 !== 1'b1 && n < 200);
        checks++;
        if (n != 64) begin failures++; $display("FAIL p8_period got=%0d exp=64", n); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (an8 !== 8'hFF || seg8 !== 8'hFF) begin
                failures++; $display("FAIL p8_blank cyc=%0d got=%h/%h exp=FF/FF", i, an8, seg8);
            end
        end
        tick();
        checks++;
        if (an8 !== 8'hFE || seg8 !== 8'hC0) begin
            failures++; $display("FAIL p8_digit0 got=%h/%h exp=FE/C0", an8, seg8);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_shadow();
        test_blank_dp();
        test_enable_drop();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 131072: clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter BLANK, default 1024: cycles at slot start with all anodes off (anti-ghosting), 1 <= BLANK < SCAN_DIV.
REQ-004 clock  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  high = scan running; low = display dark.
REQ-007 value  input  4*DIGITS  hex nibbles, digit 0 = bits [3:0].
REQ-008 blank  input  DIGITS  per-digit blank mask, 1 = digit dark.
REQ-009 dp  input  DIGITS  per-digit decimal point, 1 = lit.
REQ-010 an  output  DIGITS  active-low digit select, registered.
REQ-011 seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-012 frame_done  output  1  one-cycle pulse when a full scan frame completes.

Function
REQ-013 SHALL keep slot counter cnt counting 0..SCAN_DIV-1 while enable=1, wrapping to 0 after SCAN_DIV-1.
REQ-014 SHALL advance digit index idx by 1 in the cycle cnt wraps; idx DIGITS-1 wraps to 0.
REQ-015 SHALL latch value, blank, dp into shadow registers on the cycle idx wraps DIGITS-1 -> 0 and on the first cycle after enable rises; display uses only shadow data (no tearing mid-frame).
REQ-016 SHALL pulse frame_done high for exactly one cycle, coincident with the shadow latch caused by idx wrap (not by enable rise).
REQ-017 SHALL drive an all-ones while cnt < BLANK; otherwise an[idx]=0, other bits 1, unless shadow blank[idx]=1 (then all ones).
REQ-018 SHALL drive seg[6:0] = active-low hex pattern of shadow nibble idx and seg[7] = ~shadow dp[idx]; seg = all ones whenever an is all ones.
REQ-019 SHALL register an and seg: outputs reflect cnt/idx of the previous cycle (latency 1 cycle).
REQ-020 SHALL decode hex 0-F as: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (seg[6:0] with seg[7]=1, i.e. these are full bytes with dp off).
REQ-021 SHALL, while enable=0, hold cnt=0, idx=0, an all ones, seg all ones, frame_done=0.
REQ-022 SHALL treat enable falling mid-slot as immediate stop: next cycle cnt=0, idx=0, outputs dark; no frame_done.
REQ-023 SHALL ignore value/blank/dp changes between latch events.

Reset
REQ-024 SHALL on reset=0 at clock edge set cnt=0, idx=0, shadow registers=0, an all ones, seg all ones, frame_done=0; reset overrides enable.
REQ-025 SHALL, when reset releases with enable=1, treat the first enabled cycle as an enable rise (latch per REQ-015).

Structure
REQ-026 SHALL place the 16-entry hex segment pattern table and the active-low OFF constant (all ones) in the shared display package.
REQ-027 SHALL implement the hex-to-segment lookup as combinational sub-module hex7seg (4-bit in, 7-bit active-low out).
REQ-028 SHALL size cnt as clog2(SCAN_DIV) bits and idx as clog2(DIGITS) bits (min 1).

Verification (DIGITS=4, SCAN_DIV=4, BLANK=1 unless noted)
REQ-029 Reset: reset=0 two cycles, enable=1 -> an=4'hF, seg=8'hFF, frame_done=0 throughout.
REQ-030 Scan order: value=16'h3210, blank=0, dp=0 -> per slot one dark cycle then an=E/D/B/7 with seg=C0/F9/A4/B0; frame_done pulses once every 16 cycles.
REQ-031 Shadowing: change value to 16'hFFFF mid-frame -> remaining digits of frame still show 3210 patterns; next frame shows 8E on all digits.
REQ-032 Blank/dp: blank=4'b0100, dp=4'b0001 -> digit 0 seg=40, digit 2 an stays F and seg=FF for whole slot.
REQ-033 Enable drop: deassert enable during digit 2 -> next cycle an=F, seg=FF, no frame_done; re-enable restarts at digit 0 with fresh latch.
REQ-034 Default params: one full frame -> frame_done period exactly 8*131072 cycles.
